// File: rtl/countdown_timer_8_bits.sv
// Loadable 8-bit down-counter with prescaler, one-shot/auto-reload and pause.
// Optional sticky irq flag enabled by macro COUNTDOWN_STICKY_IRQ_EN.
module countdown_timer_8_bits #(
  parameter int DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       load,
  input  logic [7:0] din,
  input  logic       start,
  input  logic       stop,
  input  logic       auto_reload,
  output logic [7:0] q,
  output logic       busy,
  output logic       zero,
  output logic       done
`ifdef COUNTDOWN_STICKY_IRQ_EN
  ,
  input  logic       irq_clr,
  output logic       irq
`endif
);

  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]    state;
  logic [7:0]    reload;
  logic [PW-1:0] psc;

  assign busy = (state != IDLE);
  assign zero = (q == 8'd0);

  // Timer state machine: count, reload, pause and terminal pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      q      <= 8'd0;
      reload <= 8'd0;
      psc    <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            q      <= din;
            reload <= din;
            psc    <= '0;
          end else if (start) begin
            if (q != 8'd0) begin
              state <= RUN;
              psc   <= '0;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (stop) begin
            state <= HOLD;
          end else begin
            if (load)
              reload <= din;
            if (tick) begin
              if (psc == PMAX) begin
                psc <= '0;
                if (q > 8'd1) begin
                  q <= q - 8'd1;
                end else begin
                  done <= 1'b1;
                  if (auto_reload && reload != 8'd0) begin
                    q <= reload;
                  end else begin
                    q     <= 8'd0;
                    state <= IDLE;
                  end
                end
              end else begin
                psc <= psc + 1'b1;
              end
            end
          end
        end
        HOLD: begin
          if (stop) begin
            state <= IDLE;
          end else if (load) begin
            q      <= din;
            reload <= din;
            psc    <= '0;
          end else if (start) begin
            if (q != 8'd0) begin
              state <= RUN;
            end else begin
              done  <= 1'b1;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef COUNTDOWN_STICKY_IRQ_EN
  // Sticky flag: set by each done pulse, cleared by irq_clr; set wins.
  always_ff @(posedge clk) begin
    if (rst)
      irq <= 1'b0;
    else if (done)
      irq <= 1'b1;
    else if (irq_clr)
      irq <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_countdown_timer_8_bits.sv
// Directed self-checking bench for countdown_timer_8_bits.
// Drives a DIV=1 and a DIV=4 instance from shared stimulus.
module tb_countdown_timer_8_bits;

  logic       clk = 1'b0;
  logic       rst, tick, load, start, stop, auto_reload;
  logic [7:0] din;
  logic [7:0] q1, q4;
  logic       busy1, busy4, zero1, zero4, done1, done4;
`ifdef COUNTDOWN_STICKY_IRQ_EN
  logic       irq_clr, irq1, irq4;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  countdown_timer_8_bits #(.DIV(1)) u1 (
    .clk(clk), .rst(rst), .tick(tick), .load(load), .din(din),
    .start(start), .stop(stop), .auto_reload(auto_reload),
    .q(q1), .busy(busy1), .zero(zero1), .done(done1)
`ifdef COUNTDOWN_STICKY_IRQ_EN
    , .irq_clr(irq_clr), .irq(irq1)
`endif
  );

  countdown_timer_8_bits #(.DIV(4)) u4 (
    .clk(clk), .rst(rst), .tick(tick), .load(load), .din(din),
    .start(start), .stop(stop), .auto_reload(auto_reload),
    .q(q4), .busy(busy4), .zero(zero4), .done(done4)
`ifdef COUNTDOWN_STICKY_IRQ_EN
    , .irq_clr(irq_clr), .irq(irq4)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load(input logic [7:0] v);
    din = v; load = 1'b1; cyc(); load = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; cyc(); stop = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc(); rst = 1'b0;
  endtask

  // n ticks; done must stay low until the n-th, then pulse with q = eq
  task automatic period(input string tag, input int n,
                        input logic [7:0] eq, input bit sel);
    int early = 0;
    tick = 1'b1;
    repeat (n - 1) begin
      cyc();
      if ((sel ? done4 : done1) !== 1'b0) early++;
    end
    cyc();
    tick = 1'b0;
    chk({tag, "_early"}, early, 0);
    chk({tag, "_done"}, sel ? done4 : done1, 1);
    chk({tag, "_q"}, sel ? q4 : q1, eq);
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; load = 1'b0; start = 1'b0;
    stop = 1'b0; auto_reload = 1'b0; din = 8'd0;
`ifdef COUNTDOWN_STICKY_IRQ_EN
    irq_clr = 1'b0;
`endif
    cyc(); cyc();
    rst = 1'b0;

    // reset state, ticks in IDLE ignored
    chk("rst_q", q1, 0);
    chk("rst_zero", zero1, 1);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    tick = 1'b1;
    repeat (10) cyc();
    tick = 1'b0;
    chk("idle_tick_q", q1, 0);
    chk("idle_tick_busy", busy1, 0);

    // DIV=1 one-shot from 5
    pulse_load(8'd5);
    chk("ld5_q", q1, 5);
    pulse_start();
    chk("run_busy", busy1, 1);
    chk("run_q", q1, 5);
    tick = 1'b1;
    for (int i = 4; i >= 1; i--) begin
      cyc();
      chk("os_q", q1, i);
      chk("os_nodone", done1, 0);
    end
    cyc();
    chk("os_q0", q1, 0);
    chk("os_done", done1, 1);
    chk("os_busy", busy1, 0);
    chk("os_zero", zero1, 1);
    cyc();
    tick = 1'b0;
    chk("os_done_once", done1, 0);

    // DIV=4 auto-reload, reload changed mid-run
    do_reset();
    pulse_load(8'd3);
    auto_reload = 1'b1;
    pulse_start();
    period("ar1", 12, 8'd3, 1'b1);
    tick = 1'b1;
    cyc();
    chk("ar_done_gap", done4, 0);
    cyc();
    tick = 1'b0;
    chk("ar_q_mid", q4, 3);
    pulse_load(8'd2);
    chk("ar_ld_q_kept", q4, 3);
    chk("ar_ld_busy", busy4, 1);
    period("ar2", 10, 8'd2, 1'b1);
    period("ar3", 8, 8'd2, 1'b1);
    auto_reload = 1'b0;

    // pause and resume
    do_reset();
    pulse_load(8'd10);
    pulse_start();
    tick = 1'b1;
    repeat (3) cyc();
    tick = 1'b0;
    chk("ps_q7", q1, 7);
    pulse_stop();
    tick = 1'b1;
    repeat (20) cyc();
    tick = 1'b0;
    chk("hold_q", q1, 7);
    chk("hold_busy", busy1, 1);
    pulse_start();
    period("resume", 7, 8'd0, 1'b0);
    chk("resume_busy", busy1, 0);

    // stop twice aborts, q retained
    pulse_load(8'd10);
    pulse_start();
    tick = 1'b1;
    repeat (2) cyc();
    tick = 1'b0;
    pulse_stop();
    pulse_stop();
    chk("abort_busy", busy1, 0);
    chk("abort_q", q1, 8);

    // start with q=0
    do_reset();
    pulse_start();
    chk("z_done", done1, 1);
    chk("z_busy", busy1, 0);
    cyc();
    chk("z_done_once", done1, 0);

    // start+stop in RUN, stop on terminal decrement
    pulse_load(8'd5);
    pulse_start();
    start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    tick = 1'b1;
    repeat (3) cyc();
    tick = 1'b0;
    chk("ss_hold_q", q1, 5);
    chk("ss_hold_busy", busy1, 1);
    pulse_start();
    tick = 1'b1;
    repeat (4) cyc();
    chk("pre_term_q", q1, 1);
    stop = 1'b1;
    cyc();
    stop = 1'b0; tick = 1'b0;
    chk("st_term_q", q1, 1);
    chk("st_term_done", done1, 0);
    chk("st_term_busy", busy1, 1);

    // load 0 in HOLD then start
    pulse_load(8'd0);
    chk("hold_ld0_busy", busy1, 1);
    pulse_start();
    chk("hold_ld0_done", done1, 1);
    chk("hold_ld0_busy2", busy1, 0);

    // 0xFF full-range count
    pulse_load(8'hff);
    pulse_start();
    period("ff", 255, 8'd0, 1'b0);

    // reset mid-run
    pulse_load(8'd5);
    pulse_start();
    tick = 1'b1;
    repeat (2) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0; tick = 1'b0;
    chk("mr_q", q1, 0);
    chk("mr_busy", busy1, 0);
    chk("mr_done", done1, 0);

`ifdef COUNTDOWN_STICKY_IRQ_EN
    pulse_start();
    chk("irq_pre", irq1, 0);
    cyc();
    chk("irq_set", irq1, 1);
    cyc();
    chk("irq_hold", irq1, 1);
    irq_clr = 1'b1; cyc(); irq_clr = 1'b0;
    chk("irq_clr", irq1, 0);
    pulse_start();
    irq_clr = 1'b1; cyc(); irq_clr = 1'b0;
    chk("irq_setwins", irq1, 1);
    do_reset();
    chk("irq_rst", irq1, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
